// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and
// captures the fetched word into the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic [31:0] fetch_count
);

  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] pc_plus4_f;
  logic [XLEN-1:0] pc_next;

  // Sequential PC increment; wraps silently at the top of the address space.
  always_comb begin
    pc_plus4_f = pc_f + XLEN'(4);
  end

  // Next-PC select: redirect beats stall; redirect target is word-aligned.
  always_comb begin
    pc_next = pc_plus4_f;
    if (pc_src_e) begin
      pc_next = {pc_target_e[XLEN-1:2], 2'b00};
    end else if (stall_f) begin
      pc_next = pc_f;
    end
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_f <= RESET_PC;
    end else begin
      pc_f <= pc_next;
    end
  end

  // Memory address is the fetch PC itself; the read returns in the same cycle.
  assign imem_addr = pc_f;

  // IF/ID register and fetch counter: flush beats stall; only real loads count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_d     <= NOP_INSTR;
      pc_d        <= '0;
      pc_plus4_d  <= '0;
      valid_d     <= 1'b0;
      fetch_count <= '0;
    end else if (flush_d) begin
      instr_d     <= NOP_INSTR;
      pc_d        <= '0;
      pc_plus4_d  <= '0;
      valid_d     <= 1'b0;
    end else if (!stall_d) begin
      instr_d     <= imem_rd;
      pc_d        <= pc_f;
      pc_plus4_d  <= pc_plus4_f;
      valid_d     <= 1'b1;
      fetch_count <= fetch_count + XLEN'(1);
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized control traffic,
// all checked against a cycle-level reference model of the fetch rules.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        stall_f;
  logic        stall_d;
  logic        flush_d;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic [31:0] pc_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic [31:0] fetch_count;

  // Instruction memory: 64 words, address bits [7:2] select the word.
  logic [31:0] mem [64];
  assign imem_rd = mem[imem_addr[7:2]];

  fetch_stage #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .pc_src_e    (pc_src_e),
    .pc_target_e (pc_target_e),
    .imem_addr   (imem_addr),
    .imem_rd     (imem_rd),
    .pc_f        (pc_f),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pc_plus4_d  (pc_plus4_d),
    .valid_d     (valid_d),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4d, m_cnt;
  logic        m_valid;
  bit          armed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock: predict from the current inputs, clock, then compare.
  task automatic tick();
    logic [31:0] n_pc, n_instr, n_pcd, n_pc4d, n_cnt;
    logic        n_valid;
    n_pc = m_pc; n_instr = m_instr; n_pcd = m_pcd; n_pc4d = m_pc4d;
    n_cnt = m_cnt; n_valid = m_valid;
    if (!rst_n) begin
      n_pc = RESET_PC; n_instr = NOP_INSTR; n_pcd = 0; n_pc4d = 0;
      n_valid = 0; n_cnt = 0;
    end else begin
      if (pc_src_e)     n_pc = pc_target_e & 32'hFFFF_FFFC;
      else if (stall_f) n_pc = m_pc;
      else              n_pc = m_pc + 32'd4;
      if (flush_d) begin
        n_instr = NOP_INSTR; n_pcd = 0; n_pc4d = 0; n_valid = 0;
      end else if (!stall_d) begin
        n_instr = mem[m_pc[7:2]]; n_pcd = m_pc; n_pc4d = m_pc + 32'd4;
        n_valid = 1; n_cnt = m_cnt + 32'd1;
      end
    end
    @(posedge clk);
    #1;
    if (!rst_n) armed = 1;
    m_pc = n_pc; m_instr = n_instr; m_pcd = n_pcd; m_pc4d = n_pc4d;
    m_cnt = n_cnt; m_valid = n_valid;
    if (armed) begin
      check("pc_f", pc_f, m_pc);
      check("imem_addr", imem_addr, m_pc);
      check("instr_d", instr_d, m_instr);
      check("pc_d", pc_d, m_pcd);
      check("pc_plus4_d", pc_plus4_d, m_pc4d);
      check("valid_d", 32'(valid_d), 32'(m_valid));
      check("fetch_count", fetch_count, m_cnt);
    end
  endtask

  task automatic idle();
    rst_n = 1; stall_f = 0; stall_d = 0; flush_d = 0; pc_src_e = 0; pc_target_e = 0;
  endtask

  task automatic redirect(input logic [31:0] tgt);
    idle();
    pc_src_e = 1; pc_target_e = tgt;
    tick();
    idle();
  endtask

  logic [31:0] cnt_hold, pcd_hold, instr_hold;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h00A0_0293;
    mem[1] = 32'h0000_0313;
    mem[2] = 32'h0000_0393;
    mem[6] = 32'h03F2_8C63;

    // 1: reset then free-run
    idle();
    rst_n = 0;
    tick(); tick();
    check("t1_rst_pc", pc_f, 32'h0);
    check("t1_rst_instr", instr_d, 32'h13);
    check("t1_rst_valid", 32'(valid_d), 32'h0);
    check("t1_rst_cnt", fetch_count, 32'h0);
    idle();
    tick();
    check("t1_pc4", pc_f, 32'h4);
    check("t1_i0", instr_d, 32'h00A0_0293);
    check("t1_pcd0", pc_d, 32'h0);
    tick();
    check("t1_i1", instr_d, 32'h0000_0313);
    check("t1_pcd1", pc_d, 32'h4);
    tick();
    check("t1_pcC", pc_f, 32'hC);
    check("t1_i2", instr_d, 32'h0000_0393);
    check("t1_pcd2", pc_d, 32'h8);
    check("t1_cnt3", fetch_count, 32'd3);

    // 2: stall holds PC and IF/ID
    redirect(32'h20);
    cnt_hold = fetch_count; pcd_hold = pc_d; instr_hold = instr_d;
    stall_f = 1; stall_d = 1;
    tick(); tick();
    check("t2_pc_hold", pc_f, 32'h20);
    check("t2_cnt_hold", fetch_count, cnt_hold);
    check("t2_pcd_hold", pc_d, pcd_hold);
    check("t2_instr_hold", instr_d, instr_hold);
    idle();
    tick();
    check("t2_release_pcd", pc_d, 32'h20);
    check("t2_release_cnt", fetch_count, cnt_hold + 32'd1);

    // 3: branch redirect with flush
    redirect(32'h4C);
    pc_src_e = 1; pc_target_e = 32'h18; flush_d = 1;
    tick();
    check("t3_pc", pc_f, 32'h18);
    check("t3_bubble", instr_d, 32'h13);
    check("t3_valid", 32'(valid_d), 32'h0);
    idle();
    tick();
    check("t3_pcd", pc_d, 32'h18);
    check("t3_instr", instr_d, 32'h03F2_8C63);

    // 4: redirect during stall, unaligned target
    cnt_hold = fetch_count;
    stall_f = 1; stall_d = 1; pc_src_e = 1; flush_d = 1; pc_target_e = 32'h1B;
    tick();
    check("t4_pc_aligned", pc_f, 32'h18);
    check("t4_bubble", instr_d, 32'h13);
    check("t4_valid", 32'(valid_d), 32'h0);
    check("t4_cnt", fetch_count, cnt_hold);
    idle();

    // 5: wrap-around
    redirect(32'hFFFF_FFFC);
    tick();
    check("t5_pc_wrap", pc_f, 32'h0);
    check("t5_pc4d_wrap", pc_plus4_d, 32'h0);
    check("t5_pcd", pc_d, 32'hFFFF_FFFC);

    // 6: reset mid-stream
    redirect(32'h30);
    rst_n = 0; stall_f = 1; pc_src_e = 1; pc_target_e = 32'h40;
    tick();
    check("t6_pc", pc_f, RESET_PC);
    check("t6_valid", 32'(valid_d), 32'h0);
    check("t6_cnt", fetch_count, 32'h0);
    idle();
    tick();
    check("t6_first_pcd", pc_d, RESET_PC);

    // Randomized control traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst_n       = ($urandom_range(0, 39) != 0);
      stall_f     = ($urandom_range(0, 3) == 0);
      stall_d     = ($urandom_range(0, 3) == 0);
      flush_d     = ($urandom_range(0, 5) == 0);
      pc_src_e    = ($urandom_range(0, 7) == 0);
      pc_target_e = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC - 32'($urandom_range(0, 7))
                                                 : $urandom;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
